// File: rtl/dds_spi_loader.sv
// rtl/dds_spi_loader.sv - serialises the five-word DDS register set over a 3-wire SPI link
module dds_spi_loader #(
    parameter int          CLK_DIV    = 4,
    parameter int          GAP        = 4,
    parameter logic [15:0] RESET_WORD = 16'h2100
) (
    input  logic        SYS_CLK,
    input  logic        RST_N,
    input  logic [7:0]  dds_control_reg,
    input  logic [15:0] dds_frequency_reg0_LSB,
    input  logic [15:0] dds_frequency_reg0_MSB,
    input  logic [15:0] dds_phase_reg0,
    input  logic [15:0] dds_exit_reset,
    output logic        DDS_SCLK,
    output logic        DDS_SDATA,
    output logic        DDS_FSYNC,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_FS_SETUP  = 3'd2;
    localparam logic [2:0] ST_SCLK_LOW  = 3'd3;
    localparam logic [2:0] ST_SCLK_HIGH = 3'd4;
    localparam logic [2:0] ST_FS_HOLD   = 3'd5;
    localparam logic [2:0] ST_GAP       = 3'd6;
    localparam logic [2:0] ST_DONE      = 3'd7;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(GAP - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [7:0]  half_cnt;
    logic [3:0]  bit_idx;
    logic [2:0]  word_idx;
    logic [15:0] shadow [0:4];
    logic [15:0] cur_word;
    logic        sync_q1;
    logic        sync_q2;
    logic        edge_q;
    logic        req_pending;
    logic        rise;
    logic        tick;
    logic        in_frame;
    logic        unused_ctl;

    assign unused_ctl = ^dds_control_reg[7:1];

    // Load request crosses from the SCL domain through a 2-flop synchroniser
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q1     <= 1'b0;
            sync_q2     <= 1'b0;
            edge_q      <= 1'b0;
            req_pending <= 1'b0;
        end else begin
            sync_q1     <= dds_control_reg[0];
            sync_q2     <= sync_q1;
            edge_q      <= sync_q2;
            // A new edge landing on the LOAD cycle must survive the clear
            req_pending <= rise | (req_pending & (state != ST_LOAD));
        end
    end

    assign rise = sync_q2 & ~edge_q;
    assign tick = (half_cnt == 8'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (req_pending || rise) state_nxt = ST_LOAD;
            ST_LOAD:      state_nxt = ST_FS_SETUP;
            ST_FS_SETUP:  if (tick) state_nxt = ST_SCLK_LOW;
            ST_SCLK_LOW:  if (tick) state_nxt = (bit_idx == 4'd0) ? ST_FS_HOLD : ST_SCLK_HIGH;
            ST_SCLK_HIGH: if (tick) state_nxt = ST_SCLK_LOW;
            ST_FS_HOLD:   if (tick) state_nxt = ST_GAP;
            ST_GAP:       if (tick) state_nxt = (word_idx == 3'd4) ? ST_DONE : ST_FS_SETUP;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            half_cnt <= 8'd0;
            bit_idx  <= 4'd0;
            word_idx <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                half_cnt <= (state_nxt == ST_GAP) ? GAP_RELOAD : DIV_RELOAD;
            else if (!tick)
                half_cnt <= half_cnt - 8'd1;
            case (state)
                ST_LOAD: begin
                    word_idx <= 3'd0;
                    bit_idx  <= 4'd15;
                end
                ST_SCLK_LOW: if (tick && bit_idx != 4'd0) bit_idx <= bit_idx - 4'd1;
                ST_GAP: if (tick && word_idx != 3'd4) begin
                    word_idx <= word_idx + 3'd1;
                    bit_idx  <= 4'd15;
                end
                default: ;
            endcase
        end
    end

    // Words are frozen here so register writes mid-sequence only affect the next load
    always_ff @(posedge SYS_CLK) begin
        if (state == ST_LOAD) begin
            shadow[0] <= RESET_WORD;
            shadow[1] <= dds_frequency_reg0_LSB;
            shadow[2] <= dds_frequency_reg0_MSB;
            shadow[3] <= dds_phase_reg0;
            shadow[4] <= dds_exit_reset;
        end
    end

    always_comb begin
        cur_word = 16'h0000;
        case (word_idx)
            3'd0:    cur_word = shadow[0];
            3'd1:    cur_word = shadow[1];
            3'd2:    cur_word = shadow[2];
            3'd3:    cur_word = shadow[3];
            3'd4:    cur_word = shadow[4];
            default: cur_word = 16'h0000;
        endcase
    end

    assign in_frame  = (state == ST_FS_SETUP) || (state == ST_SCLK_LOW) ||
                       (state == ST_SCLK_HIGH) || (state == ST_FS_HOLD);
    assign DDS_SCLK  = (state != ST_SCLK_LOW);
    assign DDS_FSYNC = ~in_frame;
    assign DDS_SDATA = in_frame & cur_word[bit_idx];
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule
